// File: rtl/kf8259_in_service_control_pkg.sv
// Shared types and priority helpers for the KF8259 in-service stage.
// Level n is bit n; in rotated space, bit 0 is the highest-priority level.
package kf8259_in_service_control_pkg;

    typedef enum logic [2:0] {
        OCW2_ROT_AEOI_CLR = 3'b000,
        OCW2_NS_EOI       = 3'b001,
        OCW2_NOP          = 3'b010,
        OCW2_SP_EOI       = 3'b011,
        OCW2_ROT_AEOI_SET = 3'b100,
        OCW2_ROT_NS_EOI   = 3'b101,
        OCW2_SET_PRI      = 3'b110,
        OCW2_ROT_SP_EOI   = 3'b111
    } ocw2_cmd_t;

    localparam logic [2:0] ROTATE_RESET = 3'b111;

    // Shift amount is rotate+1, so rotate = 7 leaves the vector untouched.
    function automatic logic [7:0] rotate_right(input logic [7:0] source, input logic [2:0] rotate);
        logic [15:0] doubled;
        logic [3:0]  amount;
        amount  = {1'b0, rotate} + 4'd1;
        doubled = {source, source} >> amount;
        return doubled[7:0];
    endfunction

    function automatic logic [7:0] rotate_left(input logic [7:0] source, input logic [2:0] rotate);
        logic [15:0] doubled;
        logic [3:0]  amount;
        amount  = {1'b0, rotate} + 4'd1;
        doubled = {source, source} << amount;
        return doubled[15:8];
    endfunction

    function automatic logic [7:0] resolv_priority(input logic [7:0] source);
        logic [7:0] negated;
        negated = ~source + 8'd1;
        return source & negated;
    endfunction

    function automatic logic [7:0] num2bit(input logic [2:0] source);
        return 8'd1 << source;
    endfunction

    function automatic logic [2:0] bit2num(input logic [7:0] source);
        logic [2:0] number;
        number = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (source[i]) number = 3'(i);
        end
        return number;
    endfunction

    // True when one-hot level a ranks strictly above one-hot level b.
    function automatic logic higher_priority(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] rotate);
        logic [7:0] rot_a;
        logic [7:0] rot_b;
        rot_a = rotate_right(a, rotate);
        rot_b = rotate_right(b, rotate);
        return (rot_a != 8'd0) && ((rot_b == 8'd0) || (rot_a < rot_b));
    endfunction

endpackage

// File: rtl/kf8259_in_service_control_priority_compare.sv
// Combinational priority resolution: highest request, highest in-service level,
// and whether the request may interrupt the level currently being serviced.
module kf8259_priority_compare
    import kf8259_in_service_control_pkg::*;
(
    input  logic [7:0] interrupt_request_register_i,
    input  logic [7:0] interrupt_mask_i,
    input  logic [7:0] in_service_register_i,
    input  logic       special_mask_mode_i,
    input  logic [2:0] priority_rotate_i,
    output logic [7:0] req_hi_o,
    output logic [7:0] isr_hi_o,
    output logic       pending_o
);

    logic [7:0] masked_request;
    logic [7:0] isr_effective;

    always_comb begin
        masked_request = interrupt_request_register_i & ~interrupt_mask_i;
        // In special mask mode a masked in-service level no longer blocks lower levels.
        isr_effective  = special_mask_mode_i ? (in_service_register_i & ~interrupt_mask_i)
                                             : in_service_register_i;
        req_hi_o  = rotate_left(resolv_priority(rotate_right(masked_request, priority_rotate_i)),
                                priority_rotate_i);
        isr_hi_o  = rotate_left(resolv_priority(rotate_right(isr_effective, priority_rotate_i)),
                                priority_rotate_i);
        pending_o = higher_priority(req_hi_o, isr_hi_o, priority_rotate_i);
    end

endmodule

// File: rtl/kf8259_in_service_control.sv
// KF8259 in-service register, priority rotation, OCW2 command execution and
// auto-EOI; raises INT toward the CPU and reports the acknowledged level.
module kf8259_in_service_control
    import kf8259_in_service_control_pkg::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       initialize_i,
    input  logic [7:0] interrupt_request_register_i,
    input  logic [7:0] interrupt_mask_i,
    input  logic       special_mask_mode_i,
    input  logic       auto_eoi_config_i,
    input  logic       latch_in_service_i,
    input  logic       end_of_acknowledge_sequence_i,
    input  logic       ocw2_write_i,
    input  logic [2:0] ocw2_command_i,
    input  logic [2:0] ocw2_level_i,
    output logic [7:0] in_service_register_o,
    output logic [2:0] priority_rotate_o,
    output logic       interrupt_o,
    output logic [2:0] interrupt_id_o,
    output logic [7:0] clear_interrupt_request_o
);

    logic [7:0] isr_q, isr_d;
    logic [2:0] priority_rotate_q, priority_rotate_d;
    logic       rotate_in_aeoi_q, rotate_in_aeoi_d;
    logic       interrupt_q, interrupt_d;
    logic [2:0] interrupt_id_q, interrupt_id_d;
    logic [7:0] clear_irq_q, clear_irq_d;

    logic [7:0] req_hi;
    logic [7:0] isr_hi;
    logic       pending;
    logic [7:0] isr_set;
    logic [7:0] isr_clear;
    ocw2_cmd_t  ocw2_cmd;

    kf8259_priority_compare u_priority_compare (
        .interrupt_request_register_i (interrupt_request_register_i),
        .interrupt_mask_i             (interrupt_mask_i),
        .in_service_register_i        (isr_q),
        .special_mask_mode_i          (special_mask_mode_i),
        .priority_rotate_i            (priority_rotate_q),
        .req_hi_o                     (req_hi),
        .isr_hi_o                     (isr_hi),
        .pending_o                    (pending)
    );

    assign ocw2_cmd = ocw2_cmd_t'(ocw2_command_i);

    always_comb begin
        isr_set           = 8'd0;
        isr_clear         = 8'd0;
        priority_rotate_d = priority_rotate_q;
        rotate_in_aeoi_d  = rotate_in_aeoi_q;
        interrupt_id_d    = interrupt_id_q;
        clear_irq_d       = 8'd0;
        interrupt_d       = pending;

        if (latch_in_service_i) begin
            if (req_hi != 8'd0) begin
                isr_set        = req_hi;
                interrupt_id_d = bit2num(req_hi);
                clear_irq_d    = req_hi;
            end else begin
                interrupt_id_d = 3'd7;
            end
        end

        if (end_of_acknowledge_sequence_i && auto_eoi_config_i) begin
            isr_clear = num2bit(interrupt_id_q);
            if (rotate_in_aeoi_q) priority_rotate_d = interrupt_id_q;
        end

        // Evaluated after AEOI so an OCW2 rotation takes precedence.
        if (ocw2_write_i) begin
            case (ocw2_cmd)
                OCW2_NS_EOI: isr_clear = isr_clear | isr_hi;
                OCW2_SP_EOI: isr_clear = isr_clear | num2bit(ocw2_level_i);
                OCW2_ROT_NS_EOI: begin
                    if (isr_hi != 8'd0) begin
                        isr_clear         = isr_clear | isr_hi;
                        priority_rotate_d = bit2num(isr_hi);
                    end
                end
                OCW2_ROT_SP_EOI: begin
                    isr_clear         = isr_clear | num2bit(ocw2_level_i);
                    priority_rotate_d = ocw2_level_i;
                end
                OCW2_SET_PRI:      priority_rotate_d = ocw2_level_i;
                OCW2_ROT_AEOI_SET: rotate_in_aeoi_d  = 1'b1;
                OCW2_ROT_AEOI_CLR: rotate_in_aeoi_d  = 1'b0;
                default: ;
            endcase
        end

        // Set after clear: an acknowledge landing with an EOI for the same level keeps the bit.
        isr_d = (isr_q & ~isr_clear) | isr_set;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            isr_q             <= 8'd0;
            priority_rotate_q <= ROTATE_RESET;
            rotate_in_aeoi_q  <= 1'b0;
            interrupt_q       <= 1'b0;
            interrupt_id_q    <= 3'd0;
            clear_irq_q       <= 8'd0;
        end else if (initialize_i) begin
            isr_q             <= 8'd0;
            priority_rotate_q <= ROTATE_RESET;
            rotate_in_aeoi_q  <= 1'b0;
            interrupt_q       <= 1'b0;
            interrupt_id_q    <= 3'd0;
            clear_irq_q       <= 8'd0;
        end else begin
            isr_q             <= isr_d;
            priority_rotate_q <= priority_rotate_d;
            rotate_in_aeoi_q  <= rotate_in_aeoi_d;
            interrupt_q       <= interrupt_d;
            interrupt_id_q    <= interrupt_id_d;
            clear_irq_q       <= clear_irq_d;
        end
    end

    assign in_service_register_o     = isr_q;
    assign priority_rotate_o         = priority_rotate_q;
    assign interrupt_o               = interrupt_q;
    assign interrupt_id_o            = interrupt_id_q;
    assign clear_interrupt_request_o = clear_irq_q;

endmodule
